// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: op_code values, FSM states and
// the one-hot select patterns driven to the ALU output mux.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MULT = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    // Mux select bit i picks ALU function i; the illegal code selects nothing.
    localparam logic [6:0] SEL_NONE = 7'b0000000;
    localparam logic [6:0] SEL_AND  = 7'b0000001;
    localparam logic [6:0] SEL_OR   = 7'b0000010;
    localparam logic [6:0] SEL_XOR  = 7'b0000100;
    localparam logic [6:0] SEL_NOT  = 7'b0001000;
    localparam logic [6:0] SEL_ADD  = 7'b0010000;
    localparam logic [6:0] SEL_SUB  = 7'b0100000;
    localparam logic [6:0] SEL_MULT = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_WAIT = 2'd2,
        DONE     = 2'd3
    } aluState_e;

    // Map an op_code onto its mux select pattern (at most one bit set).
    function automatic logic [6:0] opSel(input logic [2:0] code);
        logic [6:0] s;
        s = SEL_NONE;
        case (code)
            OP_AND:  s = SEL_AND;
            OP_OR:   s = SEL_OR;
            OP_XOR:  s = SEL_XOR;
            OP_NOT:  s = SEL_NOT;
            OP_ADD:  s = SEL_ADD;
            OP_SUB:  s = SEL_SUB;
            OP_MULT: s = SEL_MULT;
            default: s = SEL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Operation/result handshake bundle between a requester, the ALU output mux
// and the controller. The controller sits on the slave side.
interface alu_ctrl_if #(
    parameter int k = 7
);
    logic         op_valid;
    logic [2:0]   op_code;
    logic         op_ready;
    logic [k-1:0] sel;
    logic [k-1:0] mux_out;
    logic         res_valid;
    logic         res_ready;
    logic [k-1:0] res_data;
    logic         res_err;

    modport master (
        output op_valid, op_code, mux_out, res_ready,
        input  op_ready, sel, res_valid, res_data, res_err
    );

    modport slave (
        input  op_valid, op_code, mux_out, res_ready,
        output op_ready, sel, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_lat_cnt.sv
// 4-bit multiply latency counter: load a start value, count down to zero and
// stay there; the zero flag tells the controller the multiplier has settled.
module alu_lat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] loadVal,
    input  logic       dec,
    output logic       zero
);
    logic [3:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);
endmodule

// File: rtl/alu_ctrl.sv
// ALU controller: accepts one operation at a time, steers the ALU output mux
// with a one-hot select, waits out the multiplier latency when needed and
// holds the captured result until the consumer takes it. No operand math
// happens here; every result bit comes from mux_out.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int k       = 7,   // values below 7 are not supported
    parameter int MUL_LAT = 3    // 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus
);
    aluState_e    state;
    logic [6:0]   selReg;
    logic [k-1:0] resDataReg;
    logic         resValidReg;
    logic         resErrReg;
    logic         opReadyReg;

    logic         transfer;
    logic         latLoad;
    logic         latDec;
    logic         latZero;

    assign transfer = bus.op_valid && opReadyReg;
    assign latLoad  = transfer && (bus.op_code == OP_MULT);
    assign latDec   = (state == MUL_WAIT);

    alu_lat_cnt u_latCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (latLoad),
        .loadVal (4'(MUL_LAT - 1)),
        .dec     (latDec),
        .zero    (latZero)
    );

    // Controller FSM; every output it drives is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            selReg      <= SEL_NONE;
            resValidReg <= 1'b0;
            resDataReg  <= '0;
            resErrReg   <= 1'b0;
            opReadyReg  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        opReadyReg <= 1'b0;
                        selReg     <= opSel(bus.op_code);
                        if (bus.op_code == OP_ILL) begin
                            // Nothing to compute: report the error straight away.
                            state       <= DONE;
                            resValidReg <= 1'b1;
                            resDataReg  <= '0;
                            resErrReg   <= 1'b1;
                        end else if (bus.op_code == OP_MULT) begin
                            state <= MUL_WAIT;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    resDataReg  <= bus.mux_out;
                    resValidReg <= 1'b1;
                    resErrReg   <= 1'b0;
                    selReg      <= SEL_NONE;
                    state       <= DONE;
                end
                MUL_WAIT: begin
                    if (latZero) begin
                        resDataReg  <= bus.mux_out;
                        resValidReg <= 1'b1;
                        resErrReg   <= 1'b0;
                        selReg      <= SEL_NONE;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // res_valid is always high here, so res_ready alone completes the handshake.
                    if (bus.res_ready) begin
                        resValidReg <= 1'b0;
                        opReadyReg  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Widen the 7-bit select to the mux width; bits beyond MULT stay low.
    genvar gi;
    generate
        for (gi = 0; gi < k; gi++) begin : g_sel
            if (gi < 7) begin : g_live
                assign bus.sel[gi] = selReg[gi];
            end else begin : g_tie
                assign bus.sel[gi] = 1'b0;
            end
        end
    endgenerate

    assign bus.op_ready  = opReadyReg;
    assign bus.res_valid = resValidReg;
    assign bus.res_data  = resDataReg;
    assign bus.res_err   = resErrReg;
endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: the stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every result handshake.
module tb_alu_ctrl;
    localparam int K       = 7;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_ctrl_if #(.k(K)) bus();

    alu_ctrl #(.k(K), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nCmp = 0;
    int nMis = 0;
    logic [7:0] expQ[$];   // {err, data}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitor: a handshake is due at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nMis++;
                $display("FAIL unexpected_result: got data=%0h err=%0b expected none", bus.res_data, bus.res_err);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                $display("result data=%0h err=%0b (expected data=%0h err=%0b)", bus.res_data, bus.res_err, e[6:0], e[7]);
                chk("mon_res_data", 32'(bus.res_data), 32'(e[6:0]));
                chk("mon_res_err", 32'(bus.res_err), 32'(e[7]));
            end
        end
    end

    // Select must be one-hot or zero on every cycle.
    always @(negedge clk) begin
        chk("sel_onehot0", 32'($onehot0(bus.sel)), 32'd1);
    end

    // Issue one op from IDLE and follow it cycle by cycle up to the result.
    // mux_out only carries the true value in the cycle the result is due,
    // so an early or late capture shows up as wrong data.
    task automatic doOp(input logic [2:0] code, input logic [6:0] mval);
        int         lat;
        logic [6:0] expSel;
        logic [6:0] expData;
        logic       expErr;
        lat     = (code == 3'd7) ? 1 : (code == 3'd6) ? 1 + MUL_LAT : 2;
        expSel  = (code == 3'd7) ? 7'd0 : 7'(32'd1 << code);
        expData = (code == 3'd7) ? 7'd0 : mval;
        expErr  = (code == 3'd7);
        chk("op_ready_before", 32'(bus.op_ready), 32'd1);
        bus.mux_out  = ~mval;
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        expQ.push_back({expErr, expData});
        tick();
        bus.op_valid = 1'b0;
        bus.op_code  = code + 3'd1;
        for (int i = 0; i < lat - 1; i++) begin
            chk("sel_busy", 32'(bus.sel), 32'(expSel));
            chk("res_valid_busy", 32'(bus.res_valid), 32'd0);
            chk("op_ready_busy", 32'(bus.op_ready), 32'd0);
            if (i == lat - 2) bus.mux_out = mval;
            tick();
        end
        chk("res_valid_due", 32'(bus.res_valid), 32'd1);
        chk("res_data_due", 32'(bus.res_data), 32'(expData));
        chk("res_err_due", 32'(bus.res_err), 32'(expErr));
        chk("sel_done", 32'(bus.sel), 32'd0);
        chk("op_ready_done", 32'(bus.op_ready), 32'd0);
        bus.mux_out = ~mval;
    endtask

    task automatic finishHandshake();
        tick();
        chk("res_valid_after", 32'(bus.res_valid), 32'd0);
        chk("op_ready_after", 32'(bus.op_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_code   = 3'd0;
        bus.mux_out   = 7'd0;
        bus.res_ready = 1'b0;
        #2;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_res_err", 32'(bus.res_err), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("op_ready_post_rst", 32'(bus.op_ready), 32'd1);

        // ADD, MULT, then the remaining simple ops
        bus.res_ready = 1'b1;
        doOp(3'd4, 7'h15);  finishHandshake();
        doOp(3'd6, 7'h2A);  finishHandshake();
        doOp(3'd0, 7'h01);  finishHandshake();
        doOp(3'd1, 7'h40);  finishHandshake();
        doOp(3'd3, 7'h7F);  finishHandshake();

        // XOR with the consumer stalled for 5 cycles; new requests are ignored
        bus.res_ready = 1'b0;
        doOp(3'd2, 7'h5A);
        for (int i = 0; i < 5; i++) begin
            bus.op_valid = 1'b1;
            bus.op_code  = 3'd4;
            bus.mux_out  = 7'(i * 3 + 1);
            tick();
            chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_res_data", 32'(bus.res_data), 32'h5A);
            chk("bp_op_ready", 32'(bus.op_ready), 32'd0);
            chk("bp_sel", 32'(bus.sel), 32'd0);
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b1;
        finishHandshake();
        tick();
        chk("bp_no_ghost_sel", 32'(bus.sel), 32'd0);
        chk("bp_no_ghost_ready", 32'(bus.op_ready), 32'd1);

        // Illegal op, then a legal op clears the error flag
        doOp(3'd7, 7'h33);  finishHandshake();
        doOp(3'd5, 7'h0C);  finishHandshake();

        // Reset in the middle of a MULT
        bus.mux_out  = 7'h66;
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd6;
        tick();
        bus.op_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(bus.sel), 32'd0);
        chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_op_ready", 32'(bus.op_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_stale", 32'(bus.res_valid), 32'd0);
            tick();
        end

        // Back-to-back AND then SUB with op_valid held and res_ready tied high
        bus.mux_out  = 7'h33;
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd0;
        expQ.push_back({1'b0, 7'h33});
        tick();                                   // AND accepted
        bus.op_code = 3'd5;
        chk("b2b_sel_and", 32'(bus.sel), 32'h01);
        expQ.push_back({1'b0, 7'h4C});
        tick();                                   // AND captured
        chk("b2b_and_valid", 32'(bus.res_valid), 32'd1);
        chk("b2b_done_ready", 32'(bus.op_ready), 32'd0);
        bus.mux_out = 7'h4C;
        tick();                                   // handshake, back to IDLE
        chk("b2b_idle_ready", 32'(bus.op_ready), 32'd1);
        tick();                                   // SUB accepted
        bus.op_valid = 1'b0;
        chk("b2b_sel_sub", 32'(bus.sel), 32'h20);
        tick();                                   // SUB captured
        chk("b2b_sub_valid", 32'(bus.res_valid), 32'd1);
        chk("b2b_sub_data", 32'(bus.res_data), 32'h4C);
        finishHandshake();

        repeat (2) tick();
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter k, default 7, operand/result width (must match the ALU output mux width).
REQ-002 SHALL have parameter MUL_LAT, default 3, cycles the multiplier needs before its mux input is stable (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port op_valid  input  1  requester presents an operation.
REQ-006 SHALL have port op_code  input  3  0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SUB, 6 MULT, 7 illegal.
REQ-007 SHALL have port op_ready  output  1  controller can accept an operation.
REQ-008 SHALL have port sel  output  k  one-hot select driven to the ALU output mux; bit i = op_code i.
REQ-009 SHALL have port mux_out  input  k  result from the ALU output mux.
REQ-010 SHALL have port res_valid  output  1  res_data/res_err valid.
REQ-011 SHALL have port res_ready  input  1  consumer accepts result.
REQ-012 SHALL have port res_data  output  k  registered result.
REQ-013 SHALL have port res_err  output  1  result came from illegal op_code.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, MUL_WAIT, DONE.
REQ-015 SHALL assert op_ready only in IDLE; transfer occurs when op_valid && op_ready.
REQ-016 SHALL on transfer of op_code 0..5 go IDLE->EXEC, registering sel = one-hot(op_code).
REQ-017 SHALL on transfer of op_code 6 go IDLE->MUL_WAIT, set sel[6], load latency counter with MUL_LAT-1.
REQ-018 SHALL on transfer of op_code 7 go IDLE->DONE directly, sel all-zero, res_data 0, res_err 1.
REQ-019 SHALL in EXEC capture mux_out into res_data, set res_valid, go DONE (op accepted at edge N -> res_valid from edge N+2).
REQ-020 SHALL in MUL_WAIT decrement counter each cycle; when counter is 0, capture mux_out, set res_valid, go DONE (MULT result at edge N+1+MUL_LAT).
REQ-021 SHALL hold sel stable from acceptance through capture; sel SHALL be all-zero in IDLE and DONE.
REQ-022 SHALL never drive more than one sel bit high (one-hot or zero at all times).
REQ-023 SHALL in DONE hold res_valid, res_data, res_err stable until res_valid && res_ready, then clear res_valid and go IDLE.
REQ-024 SHALL make a new op acceptable no earlier than the cycle after the result handshake (one op in flight; op_ready low in DONE even if res_ready high).
REQ-025 SHALL ignore op_valid and op_code changes outside IDLE.
REQ-026 SHALL clear res_err on every non-illegal capture.
REQ-027 SHALL treat k < 7 as unsupported; sel bits above 6 SHALL be 0.

Reset
REQ-028 SHALL on rst_n low, immediately and asynchronously: state IDLE, sel 0, counter 0, res_valid 0, res_data 0, res_err 0.
REQ-029 SHALL abandon any in-flight op on reset mid-operation; no result emitted after rst_n deasserts.
REQ-030 SHALL drive op_ready 1 on the first cycle after rst_n deasserts.

Structure
REQ-031 SHALL place op_code constants (OP_AND..OP_ILL), FSM state typedef and one-hot sel constants in shared package alu_pkg.
REQ-032 SHALL implement the multiply latency counter as sub-module alu_lat_cnt (load, decrement, zero flag; 4-bit).
REQ-033 SHALL contain no arithmetic on operands; all data flows through the ALU output mux.

Verification
REQ-034 SHALL cover ADD: op_code 4 accepted edge 0, mux_out=7'h15 -> sel=7'b0010000 during EXEC, res_valid edge 2, res_data=7'h15, res_err 0.
REQ-035 SHALL cover MULT with MUL_LAT=3: op_code 6 at edge 0 -> sel=7'b1000000 edges 1..3, res_valid edge 4, res_data=mux_out sampled at edge 4.
REQ-036 SHALL cover backpressure: res_ready low 5 cycles after XOR result -> res_data/res_valid stable, op_ready 0, new op_valid ignored.
REQ-037 SHALL cover illegal op_code 7 -> sel 0 throughout, res_valid edge 1, res_data 0, res_err 1; next legal op clears res_err.
REQ-038 SHALL cover reset mid-MULT (rst_n low at edge 2) -> sel 0 and res_valid 0 immediately, op_ready 1 after release, no stale result.
REQ-039 SHALL cover back-to-back: res_ready tied 1, op_valid held 1 with AND then SUB -> one op per 3 cycles, sel never multi-hot.
